// File: rtl/sqrt_result_collector.sv
// sqrt_result_collector: return-path reorder stage for the formula worker array.
// Captures per-worker results that may finish out of order and re-emits them
// on one valid/ready stream in the order the tasks were issued.
// Optional build macro: SQRT_COLLECTOR_BYPASS_EN. When it is defined, a result
// arriving for the head slot is shown on res in the same cycle.
module sqrt_result_collector #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 32,
    parameter int unsigned TAG_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_vld,
    input  logic [TAG_W-1:0] issue_slot,
    input  logic [N-1:0]     slot_vld,
    input  logic [N*W-1:0]   slot_res,
    output logic             res_vld,
    output logic [W-1:0]     res,
    input  logic             res_rdy,
    output logic             busy,
    output logic             err_overflow
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [TAG_W-1:0] fifo_mem [N];
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] head;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     slot_full;
    logic [N-1:0]     slot_full_nxt;
    logic [N-1:0]     slot_wr;
    logic [N-1:0]     slot_pop;
    logic [N-1:0]     byp_take;
    logic [W-1:0]     slot_buf [N];
    logic             fifo_nonempty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             err_set;

    assign head          = fifo_mem[rd_ptr];
    assign fifo_nonempty = (count != '0);
    assign fifo_full     = (count == CNT_W'(N));
    assign busy          = fifo_nonempty;

    // In-order output: head slot's buffered result, zero when nothing is ready
    always_comb begin
        res_vld = 1'b0;
        res     = '0;
`ifdef SQRT_COLLECTOR_BYPASS_EN
        res_vld = fifo_nonempty & (slot_full[head] | slot_vld[head]);
        if (fifo_nonempty && slot_full[head]) begin
            res = slot_buf[head];
        end else if (fifo_nonempty && slot_vld[head]) begin
            res = slot_res[int'(head)*W +: W];
        end
`else
        res_vld = fifo_nonempty & slot_full[head];
        if (res_vld) begin
            res = slot_buf[head];
        end
`endif
    end

    // Pop/push decisions, slot occupancy update and protocol-error detection
    always_comb begin
        pop           = res_vld & res_rdy;
        push_ok       = issue_vld & (~fifo_full | pop);
        err_set       = issue_vld & fifo_full & ~pop;
        slot_pop      = pop ? (N'(1) << head) : '0;
        // A popped slot that was not full can only be a bypassed result: nothing to store
        byp_take      = slot_pop & ~slot_full;
        slot_full_nxt = slot_full;
        slot_wr       = '0;
        for (int i = 0; i < N; i++) begin
            if (slot_vld[i] && !byp_take[i]) begin
                slot_wr[i]       = 1'b1;
                slot_full_nxt[i] = 1'b1;
                if (slot_full[i] && !slot_pop[i]) begin
                    err_set = 1'b1;
                end
            end else if (slot_pop[i]) begin
                slot_full_nxt[i] = 1'b0;
            end
        end
    end

    // Control state: pointers, occupancy count, slot-full flags, sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            slot_full    <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= (rd_ptr == TAG_W'(N - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= (wr_ptr == TAG_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            slot_full <= slot_full_nxt;
            if (err_set) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Data storage: tag FIFO entries and per-slot result buffers (no reset needed)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= issue_slot;
        end
        for (int i = 0; i < N; i++) begin
            if (slot_wr[i]) begin
                slot_buf[i] <= slot_res[i*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_sqrt_result_collector.sv
// Testbench for sqrt_result_collector: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sqrt_result_collector;

    localparam int unsigned N     = 8;
    localparam int unsigned W     = 32;
    localparam int unsigned TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_vld;
    logic [TAG_W-1:0] issue_slot;
    logic [N-1:0]     slot_vld;
    logic [N*W-1:0]   slot_res;
    logic             res_vld;
    logic [W-1:0]     res;
    logic             res_rdy;
    logic             busy;
    logic             err_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    sqrt_result_collector #(.N(N), .W(W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_vld    (issue_vld),
        .issue_slot   (issue_slot),
        .slot_vld     (slot_vld),
        .slot_res     (slot_res),
        .res_vld      (res_vld),
        .res          (res),
        .res_rdy      (res_rdy),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: issue-order queue of tags, per-slot occupancy and data
    int          q[$];
    bit          mfull [N];
    logic [31:0] mbuf  [N];
    bit          merr = 1'b0;
    logic [31:0] out_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model_upd
        bit mv;
        bit mpop;
        int h;
        if (!rst) begin
            q.delete();
            for (int i = 0; i < N; i++) mfull[i] = 1'b0;
            merr = 1'b0;
        end else begin
            h    = (q.size() != 0) ? q[0] : -1;
            mv   = (h >= 0) && mfull[h];
            mpop = mv && res_rdy;
            for (int i = 0; i < N; i++) begin
                if (slot_vld[i]) begin
                    if (mfull[i] && !(mpop && h == i)) merr = 1'b1;
                    mfull[i] = 1'b1;
                    mbuf[i]  = slot_res[i*W +: W];
                end else if (mpop && h == i) begin
                    mfull[i] = 1'b0;
                end
            end
            if (mpop) void'(q.pop_front());
            if (issue_vld) begin
                if (q.size() < N) q.push_back(int'(issue_slot));
                else merr = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clk) begin : compare
        bit          ev;
        logic [31:0] er;
        if (rst) begin
            ev = (q.size() != 0) && mfull[q[0]];
            er = ev ? mbuf[q[0]] : 32'h0;
            chk("res_vld", 32'(res_vld), 32'(ev));
            chk("res", res, er);
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("err_overflow", 32'(err_overflow), 32'(merr));
            if (res_vld && res_rdy) out_q.push_back(res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        issue_vld = 1'b0;
        slot_vld  = '0;
    endtask

    task automatic issue(input int s);
        issue_vld  = 1'b1;
        issue_slot = TAG_W'(s);
    endtask

    task automatic set_res(input int s, input logic [31:0] v);
        slot_vld[s]          = 1'b1;
        slot_res[s*W +: W]   = v;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] exp_out [20];
        rst        = 1'b0;
        issue_vld  = 1'b0;
        issue_slot = '0;
        slot_vld   = '0;
        slot_res   = '0;
        res_rdy    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res_vld", 32'(res_vld), 32'h0);
        chk("reset_res", res, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_err", 32'(err_overflow), 32'h0);
        rst = 1'b1;
        step();

        // Single task on slot 3
        issue(3); step();
        chk("single_busy", 32'(busy), 32'h1);
        repeat (4) step();
        set_res(3, 32'h0000_0010); step();
        chk("single_vld", 32'(res_vld), 32'h1);
        chk("single_res", res, 32'h10);
        step();
        chk("single_idle", 32'(busy), 32'h0);

        // Out-of-order completion
        issue(0); step();
        issue(1); step();
        issue(2); step();
        set_res(2, 32'hC); step();
        chk("ooo_hold_c", 32'(res_vld), 32'h0);
        set_res(1, 32'hB); step();
        chk("ooo_hold_b", 32'(res_vld), 32'h0);
        set_res(0, 32'hA); step();
        chk("ooo_first_vld", 32'(res_vld), 32'h1);
        chk("ooo_first_res", res, 32'hA);
        repeat (3) step();

        // Backpressure with two buffered results
        res_rdy = 1'b0;
        issue(5); step();
        issue(6); step();
        set_res(5, 32'h111); set_res(6, 32'h222); step();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_vld", 32'(res_vld), 32'h1);
            chk("bp_res", res, 32'h111);
        end
        res_rdy = 1'b1;
        step();
        chk("bp_second", res, 32'h222);
        step();
        chk("bp_idle", 32'(busy), 32'h0);

        // Slot reuse: slot 4 pops and receives new data in the same cycle
        res_rdy = 1'b0;
        issue(4); step();
        issue(7); step();
        set_res(4, 32'h44); step();
        res_rdy = 1'b1;
        issue(4); set_res(4, 32'h55); step();
        chk("reuse_no_err", 32'(err_overflow), 32'h0);
        chk("reuse_wait7", 32'(res_vld), 32'h0);
        set_res(7, 32'h77); step();
        chk("reuse_res7", res, 32'h77);
        step();
        chk("reuse_res55", res, 32'h55);
        step();

        // Full FIFO: push with pop is legal, push without pop overflows
        res_rdy = 1'b0;
        for (int s = 0; s < 8; s++) begin
            issue(s); step();
        end
        chk("full_busy", 32'(busy), 32'h1);
        set_res(0, 32'h100); step();
        res_rdy = 1'b1;
        issue(0); step();
        res_rdy = 1'b0;
        chk("full_pushpop_no_err", 32'(err_overflow), 32'h0);
        issue(1); step();
        chk("full_overflow_err", 32'(err_overflow), 32'h1);
        res_rdy = 1'b1;
        for (int s = 1; s < 8; s++) begin
            set_res(s, 32'h100 + 32'(s)); step();
        end
        set_res(0, 32'h200); step();
        repeat (3) step();
        chk("full_drained", 32'(busy), 32'h0);

        // Asynchronous reset between clock edges
        res_rdy = 1'b0;
        issue(2); step();
        set_res(2, 32'h99); step();
        chk("pre_reset_vld", 32'(res_vld), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_vld", 32'(res_vld), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_err", 32'(err_overflow), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        res_rdy = 1'b1;
        issue(1); step();
        set_res(1, 32'hABC); step();
        chk("post_rst_vld", 32'(res_vld), 32'h1);
        chk("post_rst_res", res, 32'hABC);
        step();
        chk("post_rst_idle", 32'(busy), 32'h0);
        step();

        // Full emitted sequence in issue order
        exp_out = '{32'h10, 32'hA, 32'hB, 32'hC, 32'h111, 32'h222,
                    32'h44, 32'h77, 32'h55,
                    32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107,
                    32'h200, 32'hABC, 32'h0};
        chk("out_count", 32'(out_q.size()), 32'd19);
        for (int k = 0; k < 19; k++) begin
            if (k < out_q.size()) chk($sformatf("out_seq[%0d]", k), out_q[k], exp_out[k]);
            else chk($sformatf("out_seq[%0d]_missing", k), 32'hDEAD_BEEF, exp_out[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_result_collector.md
Name: sqrt_result_collector

Overview:
- Return-path companion to the formula task distributor.
- Captures results from N FSM-based formula workers, which may finish out of order with variable latency.
- Re-emits results on one valid/ready stream in the exact order the arguments were issued.
- Sits between the worker array outputs and the downstream consumer of `res`.

Parameters:
- N, 8, number of worker slots (2..64).
- W, 32, result data width.
- TAG_W, $clog2(N), width of a slot index.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- issue_vld  input  1  the distributor dispatched a task this cycle.
- issue_slot  input  TAG_W  index of the worker that received the task.
- slot_vld  input  N  per-worker result-valid pulse, one cycle.
- slot_res  input  N*W  per-worker results; slot i occupies bits [i*W +: W].
- res_vld  output  1  in-order result available.
- res  output  W  in-order result data.
- res_rdy  input  1  consumer accepts `res` when res_vld & res_rdy.
- busy  output  1  order FIFO non-empty.
- err_overflow  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous): order FIFO empty, all slot_full=0, res_vld=0, res=0, busy=0, err_overflow=0. Buffer contents are don't-care.
- Order FIFO:
  - Depth N, entries TAG_W wide, circular read/write pointers plus a count of width $clog2(N+1).
  - issue_vld pushes issue_slot.
  - Push while count==N is dropped and sets err_overflow.
  - Push and pop in the same cycle are both performed: count unchanged, legal even when full.
- Slot buffers:
  - Per slot: W-bit data register and a slot_full bit.
  - slot_vld[i] writes slot_res[i] and sets slot_full[i].
  - slot_vld[i] while slot_full[i]=1 and slot i is not being popped this cycle: the new data overwrites the buffer and err_overflow is set.
- Output:
  - head = FIFO entry at the read pointer.
  - res_vld = (count!=0) & slot_full[head].
  - res = slot buffer[head] when res_vld, else 0. Registered sources only; no combinational path from slot_vld or slot_res.
  - Latency: a result captured at edge t is visible at res_vld after edge t, provided its slot is at the head.
- Pop, on res_vld & res_rdy:
  - Advance the read pointer, decrement count.
  - Clear slot_full[head], unless slot_vld[head] is set in the same cycle. In that case the new data is stored, slot_full stays 1, and no error is raised (legal back-to-back slot reuse).
- Ordering:
  - Results for non-head slots are held until every earlier-issued entry has been popped.
  - Any number of slots may complete in one cycle; all are captured.
- Backpressure: res_rdy=0 holds res_vld and res stable. Workers are never stalled; buffering is one result per slot.
- busy = (count!=0).
- err_overflow clears only on reset.
- Reset asserted mid-operation discards all pending tags and buffered results immediately.

Optional Feature:
- Macro: SQRT_COLLECTOR_BYPASS_EN.
- Defined:
  - When slot_vld[head] is set and slot_full[head]=0, res_vld asserts in the same cycle with res = slot_res[head] (zero-latency combinational bypass).
  - If also accepted that cycle, the slot buffer is not written and slot_full stays 0.
- Undefined: one-cycle minimum latency as described above; no combinational input-to-output path.

Test Plan:
- Single task: issue slot 3; 5 cycles later slot_vld[3] with 0x0000_0010 -> res_vld=1 one cycle later, res=0x10; popped with res_rdy=1; busy drops to 0.
- Out-of-order: issue slots 0,1,2 on consecutive cycles; results return in order 2 (0xC), 1 (0xB), 0 (0xA) -> outputs 0xA, 0xB, 0xC in that order; nothing is emitted before slot 0's result arrives.
- Backpressure: two results buffered, res_rdy=0 for 10 cycles -> res_vld=1 and res=first result stable throughout; release -> both emitted on consecutive cycles.
- Full FIFO: with N=8, issue 8 tasks, then a 9th with no pop -> err_overflow=1, count stays 8; with a simultaneous pop -> no error, count stays 8.
- Slot reuse: slot 4 is head and full; the cycle it pops, slot_vld[4] delivers 0x55 and slot 4 was reissued -> no error; 0x55 is emitted later in the correct order.
- Async reset: assert rst=0 mid-stream between clock edges -> res_vld, busy and err_overflow go to 0 without waiting for a clock edge; after release, a fresh issue/result round trip works.
